// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 core: bus width and memory-arbiter
// state/owner encodings.
package jedro_1_defines;

    localparam int DATA_WIDTH          = 32;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

    localparam logic ARB_OWNER_I = 1'b0;
    localparam logic ARB_OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

endpackage

// File: rtl/jedro_1_bus_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags expiry on the last
// allowed cycle so the owner can abort instead of hanging forever.
module jedro_1_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (enable_i) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Firing on count LIMIT keeps the strobe up for exactly TIMEOUT_CYCLES cycles.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (r_count == LIMIT);

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one Wishbone-style memory port between instruction fetch and the
// LSU: data has priority, bounded by a streak limit so fetches cannot starve.
module jedro_1_mem_arbiter
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH     = jedro_1_defines::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter int MAX_D_STREAK   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_req_i,
    input  logic [DATA_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_stb_i,
    input  logic [3:0]            data_we_i,
    input  logic [DATA_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_ack_o,
    output logic                  data_err_o,

    output logic                  mem_stb_o,
    output logic [3:0]            mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    input  logic                  mem_err_i
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_we;
    logic [DATA_WIDTH-1:0] r_instr_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;
    logic                  r_err;
    logic [SW-1:0]         r_d_streak;

    logic w_busy;
    logic w_done;
    logic w_expired;
    logic w_grant_i;
    logic w_grant_d;

    assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_done = w_busy && (mem_ack_i || mem_err_i);

    jedro_1_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!w_busy),
        .enable_i (w_busy && !(mem_ack_i || mem_err_i)),
        .expired_o(w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_stb_i && !(instr_req_i && (r_d_streak == STREAK_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (instr_req_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done || w_expired) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_owner       <= ARB_OWNER_I;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= '0;
            r_instr_rdata <= '0;
            r_data_rdata  <= '0;
            r_err         <= 1'b0;
            r_d_streak    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_owner    <= ARB_OWNER_I;
                r_addr     <= instr_addr_i;
                r_we       <= '0;
                r_wdata    <= '0;
                r_d_streak <= '0;
            end
            if (w_grant_d) begin
                r_owner <= ARB_OWNER_D;
                r_addr  <= data_addr_i;
                r_we    <= data_we_i;
                r_wdata <= data_wdata_i;
                // The streak only matters while a fetch is actually waiting.
                if (!instr_req_i) begin
                    r_d_streak <= '0;
                end else if (r_d_streak != STREAK_MAX) begin
                    r_d_streak <= r_d_streak + 1'b1;
                end
            end
            if (w_done) begin
                r_err <= mem_err_i;
                if (r_owner == ARB_OWNER_I) r_instr_rdata <= mem_rdata_i;
                else                        r_data_rdata  <= mem_rdata_i;
            end else if (w_expired) begin
                r_err <= 1'b1;
                if (r_owner == ARB_OWNER_I) r_instr_rdata <= '0;
                else                        r_data_rdata  <= '0;
            end
        end
    end

    assign instr_gnt_o    = w_grant_i;
    assign instr_rvalid_o = (r_state == RESP) && (r_owner == ARB_OWNER_I);
    assign instr_err_o    = instr_rvalid_o && r_err;
    assign instr_rdata_o  = r_instr_rdata;

    assign data_ack_o     = (r_state == RESP) && (r_owner == ARB_OWNER_D) && !r_err;
    assign data_err_o     = (r_state == RESP) && (r_owner == ARB_OWNER_D) && r_err;
    assign data_rdata_o   = r_data_rdata;

    assign mem_stb_o      = w_busy;
    assign mem_we_o       = r_we;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = r_wdata;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter: a table of single transactions
// against a configurable slave, plus hand-written priority/streak/reset sequences.
module tb_jedro_1_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_stb_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        data_err_o;
    logic        mem_stb_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        mem_err_i;

    always #5 clk_i = ~clk_i;

    jedro_1_mem_arbiter #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16),
        .MAX_D_STREAK  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .data_stb_i    (data_stb_i),
        .data_we_i     (data_we_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rdata_o  (data_rdata_o),
        .data_ack_o    (data_ack_o),
        .data_err_o    (data_err_o),
        .mem_stb_o     (mem_stb_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ack_i     (mem_ack_i),
        .mem_err_i     (mem_err_i)
    );

    // Slave model: answers after slaveWait stalled strobe cycles.
    logic        slaveAck;
    logic        slaveErr;
    logic        spuriousAck;
    int          slaveWait;
    logic [31:0] slaveRdata;
    int          stbCycles;

    assign mem_ack_i   = (mem_stb_o && slaveAck && (stbCycles == slaveWait)) || spuriousAck;
    assign mem_err_i   = mem_stb_o && slaveErr && (stbCycles == slaveWait);
    assign mem_rdata_i = slaveRdata;

    always @(posedge clk_i) begin
        if (rst_i || !mem_stb_o || mem_ack_i || mem_err_i) stbCycles <= 0;
        else                                                stbCycles <= stbCycles + 1;
    end

    typedef struct {
        logic        isData;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waitStates;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        expErr;
        logic [31:0] expRdata;
        int          expRespCycle;
    } vec_t;

    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves the same way.
    task automatic applyStimulus(input vec_t v, input int idx);
        int respCycle;
        int stbCount;
        slaveAck   = v.ack;
        slaveErr   = v.err;
        slaveWait  = v.waitStates;
        slaveRdata = v.rdata;
        if (v.isData) begin
            data_stb_i   = 1'b1;
            data_we_i    = v.we;
            data_addr_i  = v.addr;
            data_wdata_i = v.wdata;
        end else begin
            instr_req_i  = 1'b1;
            instr_addr_i = v.addr;
        end
        @(negedge clk_i);
        checkOutput($sformatf("v%0d gnt", idx), instr_gnt_o, !v.isData);
        checkOutput($sformatf("v%0d stb at accept", idx), mem_stb_o, 0);
        @(posedge clk_i); #1;
        if (!v.isData) begin
            instr_req_i  = 1'b0;
            instr_addr_i = 32'hFFFF_FFF0;
        end
        respCycle = -1;
        stbCount  = 0;
        for (int c = 0; c < 40 && respCycle < 0; c++) begin
            @(negedge clk_i);
            if (mem_stb_o) begin
                if (stbCount == 0) begin
                    checkOutput($sformatf("v%0d mem_addr", idx), mem_addr_o, v.addr);
                    checkOutput($sformatf("v%0d mem_we", idx), mem_we_o, v.we);
                    if (v.isData) checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata_o, v.wdata);
                end
                stbCount++;
            end
            if (instr_rvalid_o || data_ack_o || data_err_o) begin
                respCycle = c;
                checkOutput($sformatf("v%0d stb in resp", idx), mem_stb_o, 0);
                if (v.isData) begin
                    checkOutput($sformatf("v%0d data_ack", idx), data_ack_o, !v.expErr);
                    checkOutput($sformatf("v%0d data_err", idx), data_err_o, v.expErr);
                    checkOutput($sformatf("v%0d data_rdata", idx), data_rdata_o, v.expRdata);
                    checkOutput($sformatf("v%0d instr_rvalid", idx), instr_rvalid_o, 0);
                end else begin
                    checkOutput($sformatf("v%0d instr_rvalid", idx), instr_rvalid_o, 1);
                    checkOutput($sformatf("v%0d instr_err", idx), instr_err_o, v.expErr);
                    checkOutput($sformatf("v%0d instr_rdata", idx), instr_rdata_o, v.expRdata);
                    checkOutput($sformatf("v%0d data pulses", idx), {data_ack_o, data_err_o}, 0);
                end
            end
            @(posedge clk_i); #1;
        end
        data_stb_i = 1'b0;
        checkOutput($sformatf("v%0d response cycle", idx), respCycle, v.expRespCycle);
        checkOutput($sformatf("v%0d stb cycles", idx), stbCount, v.expRespCycle);
        @(negedge clk_i);
        checkOutput($sformatf("v%0d idle after", idx),
                    {mem_stb_o, instr_rvalid_o, data_ack_o, data_err_o}, 0);
        @(posedge clk_i); #1;
    endtask

    logic [31:0] owners[10];
    logic        expFetch[10];
    int          recCount;
    logic        prevStb;
    vec_t        postReset;

    initial begin
        #300000;
        $display("[TB] FAIL global timeout: got hang, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        //          isData we     addr          wdata         wait ack  err  rdata         expErr expRdata     resp
        vecs[0] = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,        0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 32'h0000_0013, 1};
        vecs[1] = '{1'b1, 4'h0, 32'h0000_0040, 32'h0,        2, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3};
        vecs[2] = '{1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 32'h1111_1111, 1};
        vecs[3] = '{1'b0, 4'h0, 32'h0000_0104, 32'h0,        1, 1'b0, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0055, 2};
        vecs[4] = '{1'b0, 4'h0, 32'h0000_0108, 32'h0,        0, 1'b1, 1'b1, 32'h0000_0077, 1'b1, 32'h0000_0077, 1};
        vecs[5] = '{1'b1, 4'h0, 32'h0000_2000, 32'h0,        0, 1'b0, 1'b0, 32'h9999_9999, 1'b1, 32'h0000_0000, 16};
        vecs[6] = '{1'b1, 4'h2, 32'h0000_0044, 32'h0000_AB00, 3, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 4};
        vecs[7] = '{1'b0, 4'h0, 32'h0000_010C, 32'h0,        0, 1'b0, 1'b0, 32'h0000_AAAA, 1'b1, 32'h0000_0000, 16};
        postReset = '{1'b0, 4'h0, 32'h0000_0400, 32'h0,      0, 1'b1, 1'b0, 32'h0000_0093, 1'b0, 32'h0000_0093, 1};
        expFetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_i = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = '0;
        data_stb_i = 1'b0; data_we_i = '0; data_addr_i = '0; data_wdata_i = '0;
        slaveAck = 1'b0; slaveErr = 1'b0; spuriousAck = 1'b0; slaveWait = 0; slaveRdata = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset mem_stb", mem_stb_o, 0);
        checkOutput("reset mem_we", mem_we_o, 0);
        checkOutput("reset mem_addr", mem_addr_o, 0);
        checkOutput("reset mem_wdata", mem_wdata_o, 0);
        checkOutput("reset rdata", instr_rdata_o | data_rdata_o, 0);
        checkOutput("reset pulses", {instr_gnt_o, instr_rvalid_o, instr_err_o, data_ack_o, data_err_o}, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        spuriousAck = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            checkOutput("spurious ack idle", {mem_stb_o, instr_rvalid_o, data_ack_o, data_err_o}, 0);
            @(posedge clk_i); #1;
        end
        spuriousAck = 1'b0;
        @(negedge clk_i);
        checkOutput("spurious ack after", {mem_stb_o, instr_rvalid_o, data_ack_o, data_err_o}, 0);
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
        checkOutput("data_rdata held across fetch", data_rdata_o, 32'h1234_5678);

        // Simultaneous fetch and store: data first, fetch granted in the next IDLE.
        slaveAck = 1'b1; slaveErr = 1'b0; slaveWait = 0; slaveRdata = 32'h0;
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200;
        data_stb_i = 1'b1; data_we_i = 4'hF; data_addr_i = 32'h0000_1000; data_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        checkOutput("both: fetch gnt", instr_gnt_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("both: data first addr", mem_addr_o, 32'h0000_1000);
        checkOutput("both: mem_we", mem_we_o, 4'hF);
        checkOutput("both: mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("both: data_ack", data_ack_o, 1);
        checkOutput("both: no gnt in resp", instr_gnt_o, 0);
        @(posedge clk_i); #1;
        data_stb_i = 1'b0;
        @(negedge clk_i);
        checkOutput("both: fetch gnt next idle", instr_gnt_o, 1);
        @(posedge clk_i); #1;
        instr_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("both: fetch addr", mem_addr_o, 32'h0000_0200);
        checkOutput("both: fetch we", mem_we_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("both: instr_rvalid", instr_rvalid_o, 1);
        @(posedge clk_i); #1;

        // Streak limit: four data transactions, then the waiting fetch wins.
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0300;
        data_stb_i = 1'b1; data_we_i = 4'h0; data_addr_i = 32'h0000_0500; data_wdata_i = 32'h0;
        recCount = 0;
        prevStb  = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk_i);
            if (mem_stb_o && !prevStb && recCount < 10) begin
                owners[recCount] = mem_addr_o;
                recCount++;
            end
            prevStb = mem_stb_o;
            @(posedge clk_i); #1;
        end
        checkOutput("streak transactions seen", recCount >= 10, 1);
        for (int i = 0; i < 10 && i < recCount; i++)
            checkOutput($sformatf("streak owner %0d", i), owners[i],
                        expFetch[i] ? 32'h0000_0300 : 32'h0000_0500);
        rst_i = 1'b1; instr_req_i = 1'b0; data_stb_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Reset during the second wait cycle of a data access.
        slaveAck = 1'b1; slaveErr = 1'b0; slaveWait = 5; slaveRdata = 32'h5A5A_5A5A;
        data_stb_i = 1'b1; data_we_i = 4'h0; data_addr_i = 32'h0000_0600;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("rst: first wait stb", mem_stb_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        data_stb_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst: stb dropped", mem_stb_o, 0);
        checkOutput("rst: no data pulse", {data_ack_o, data_err_o}, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            checkOutput($sformatf("rst: quiet %0d", c), {mem_stb_o, data_ack_o, data_err_o}, 0);
        end
        @(posedge clk_i); #1;
        applyStimulus(postReset, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
